// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module : alu_pkg
// Brief  : Shared ALU function codes and sequential-shifter state encoding.
// Rev    : 1.0
// ============================================================================
package alu_pkg;

  localparam logic [5:0] SLL = 6'b000000;
  localparam logic [5:0] SRL = 6'b000010;
  localparam logic [5:0] ADD = 6'b100000;
  localparam logic [5:0] SUB = 6'b100010;
  localparam logic [5:0] AND = 6'b100100;
  localparam logic [5:0] OR  = 6'b100101;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } shift_state_e;

endpackage
`default_nettype wire

// File: rtl/shifter_sll_seq_if.sv
`default_nettype none
// ============================================================================
// Module : shifter_sll_seq_if
// Brief  : Request/result bundle between the ALU top and the SLL shifter.
// Rev    : 1.0
// ============================================================================
interface shifter_sll_seq_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [5:0]       Signal;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [WIDTH-1:0] dataOut;
  logic             busy;
  logic             done;

  modport master (
    output start, Signal, dataA, dataB,
    input  dataOut, busy, done
  );

  modport slave (
    input  start, Signal, dataA, dataB,
    output dataOut, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/shamt_down_counter.sv
`default_nettype none
// ============================================================================
// Module : shamt_down_counter
// Brief  : Loadable shift-amount down-counter with an is_one flag.
// Rev    : 1.0
// ============================================================================
module shamt_down_counter #(
  parameter int SHAMT_W = 5
) (
  input  wire logic               clk,
  input  wire logic               reset,
  input  wire logic               load,
  input  wire logic               en,
  input  wire logic [SHAMT_W-1:0] load_val,
  output logic                    is_one
);

  logic [SHAMT_W-1:0] cnt_q;
  logic [SHAMT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign is_one = (cnt_q == SHAMT_W'(1));

endmodule
`default_nettype wire

// File: rtl/shifter_sll_seq.sv
`default_nettype none
// ============================================================================
// Module : shifter_sll_seq
// Brief  : Multi-cycle logical left shifter, one bit per clock, start/busy/done.
// Rev    : 1.0
// ============================================================================
module shifter_sll_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  wire logic          clk,
  input  wire logic          reset,
  shifter_sll_seq_if.slave   bus
);

  shift_state_e       state_q, state_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic [SHAMT_W-1:0] shamt;
  logic               accept;
  logic               cnt_is_one;
  logic               unused_shamt_hi;

  assign shamt           = bus.dataB[SHAMT_W-1:0];
  assign unused_shamt_hi = ^bus.dataB[WIDTH-1:SHAMT_W];
  assign accept          = (state_q == IDLE) && bus.start && (bus.Signal == SLL);

  shamt_down_counter #(
    .SHAMT_W (SHAMT_W)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .en       (state_q == SHIFT),
    .load_val (shamt),
    .is_one   (cnt_is_one)
  );

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    dout_d  = dout_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sreg_d = bus.dataA;
          if (shamt == '0) begin
            state_d = DONE;
            dout_d  = bus.dataA;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        sreg_d = sreg_q << 1;
        // Result lands in dataOut on the same edge that enters DONE.
        if (cnt_is_one) begin
          state_d = DONE;
          dout_d  = sreg_q << 1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      dout_q  <= dout_d;
    end
  end

  assign bus.dataOut = dout_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);

endmodule
`default_nettype wire
